// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_rr_arbiter
// Purpose  : Packet-aware round-robin arbiter merging NI valid/ready byte
//            streams into one downstream stream. A grant is held for a whole
//            packet (until an accepted beat with i_last) or until BURST_MAX
//            beats have been accepted. Output goes through a 2-entry
//            register-out buffer, so every output is a flop and o_rdy has no
//            combinational path to any i_rdy.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk     in   1       clock, rising edge
//   rst     in   1       synchronous reset, active-high
//   i_rdy   out  NI      per-requester ready (only bit gnt can be 1)
//   i_en    in   NI      per-requester valid
//   i_data  in   NI*DW   requester k at [k*DW +: DW]
//   i_last  in   NI      per-requester end-of-packet, qualified by i_en
//   o_rdy   in   1       downstream ready
//   o_en    out  1       downstream valid
//   o_data  out  DW      downstream data
//   o_last  out  1       end-of-packet travelling with o_data
//   o_id    out  3       source requester index of o_data
// ============================================================================
module stream_rr_arbiter #(
   parameter int NI        = 4,
   parameter int DW        = 8,
   parameter int BURST_MAX = 0
) (
   input  logic             clk,
   input  logic             rst,
   output logic [NI-1:0]    i_rdy,
   input  logic [NI-1:0]    i_en,
   input  logic [NI*DW-1:0] i_data,
   input  logic [NI-1:0]    i_last,
   input  logic             o_rdy,
   output logic             o_en,
   output logic [DW-1:0]    o_data,
   output logic             o_last,
   output logic [2:0]       o_id
);

   localparam logic [2:0]  C_LAST_IDX = 3'(NI - 1);
   localparam logic [16:0] C_BURST    = 17'(BURST_MAX);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [2:0]      r_ptr;
   logic [2:0]      r_gnt;
   logic [15:0]     r_cnt;

   // Output buffer: head drives the outputs, tail only holds an overflow beat.
   logic            r_hd_vld;
   logic [DW-1:0]   r_hd_data;
   logic            r_hd_last;
   logic [2:0]      r_hd_id;
   logic            r_tl_vld;
   logic [DW-1:0]   r_tl_data;
   logic            r_tl_last;
   logic [2:0]      r_tl_id;

   logic            w_sel_en;
   logic [DW-1:0]   w_sel_data;
   logic            w_sel_last;
   logic            w_found;
   logic [2:0]      w_pick;
   logic            w_rdy;
   logic            w_push;
   logic            w_pop;
   logic            w_end;
   logic [16:0]     w_cnt_inc;

   // Mux the granted requester's inputs.
   always_comb begin
      w_sel_en   = 1'b0;
      w_sel_data = '0;
      w_sel_last = 1'b0;
      for (int k = 0; k < NI; k++) begin
         if (r_gnt == 3'(k)) begin
            w_sel_en   = i_en[k];
            w_sel_data = i_data[k*DW +: DW];
            w_sel_last = i_last[k];
         end
      end
   end

   // Rotating priority scan: first requester at or after ptr, wrapping.
   always_comb begin
      logic [3:0] idx;
      w_found = 1'b0;
      w_pick  = '0;
      idx     = '0;
      for (int i = 0; i < NI; i++) begin
         idx = {1'b0, r_ptr} + 4'(i);
         if (idx >= 4'(NI)) begin
            idx = idx - 4'(NI);
         end
         for (int k = 0; k < NI; k++) begin
            if (!w_found && (idx == 4'(k)) && i_en[k]) begin
               w_found = 1'b1;
               w_pick  = 3'(k);
            end
         end
      end
   end

   // Ready depends only on flops (state and tail-valid), never on o_rdy.
   assign w_rdy     = (r_state == ST_GRANT) && !r_tl_vld;
   assign w_push    = w_rdy && w_sel_en;
   assign w_pop     = r_hd_vld && o_rdy;
   assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
   assign w_end     = w_push &&
                      (w_sel_last || ((C_BURST != 17'd0) && (w_cnt_inc == C_BURST)));

   always_comb begin
      i_rdy = '0;
      for (int k = 0; k < NI; k++) begin
         if (r_gnt == 3'(k)) begin
            i_rdy[k] = w_rdy;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; IDLE always lasts one cycle between grants.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (w_end) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Grant, fairness pointer and beat counter. The pointer only moves when a
   // grant ends, so a stalled requester keeps its grant and its turn.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gnt <= '0;
         r_ptr <= '0;
         r_cnt <= '0;
      end else if (r_state == ST_IDLE) begin
         if (w_found) begin
            r_gnt <= w_pick;
         end
      end else if (w_push) begin
         if (w_end) begin
            r_ptr <= (r_gnt == C_LAST_IDX) ? 3'd0 : r_gnt + 3'd1;
            r_cnt <= '0;
         end else begin
            r_cnt <= w_cnt_inc[15:0];
         end
      end
   end

   // 2-entry output buffer. A push while full cannot happen since w_rdy
   // is low whenever the tail is occupied.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hd_vld  <= 1'b0;
         r_hd_data <= '0;
         r_hd_last <= 1'b0;
         r_hd_id   <= '0;
         r_tl_vld  <= 1'b0;
         r_tl_data <= '0;
         r_tl_last <= 1'b0;
         r_tl_id   <= '0;
      end else if (w_pop) begin
         if (r_tl_vld) begin
            r_hd_data <= r_tl_data;
            r_hd_last <= r_tl_last;
            r_hd_id   <= r_tl_id;
            r_tl_vld  <= 1'b0;
         end else if (w_push) begin
            r_hd_data <= w_sel_data;
            r_hd_last <= w_sel_last;
            r_hd_id   <= r_gnt;
         end else begin
            r_hd_vld  <= 1'b0;
         end
      end else if (w_push) begin
         if (!r_hd_vld) begin
            r_hd_vld  <= 1'b1;
            r_hd_data <= w_sel_data;
            r_hd_last <= w_sel_last;
            r_hd_id   <= r_gnt;
         end else begin
            r_tl_vld  <= 1'b1;
            r_tl_data <= w_sel_data;
            r_tl_last <= w_sel_last;
            r_tl_id   <= r_gnt;
         end
      end
   end

   assign o_en   = r_hd_vld;
   assign o_data = r_hd_data;
   assign o_last = r_hd_last;
   assign o_id   = r_hd_id;

endmodule
`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_rr_arbiter
// Purpose  : Self-checking bench for stream_rr_arbiter. Instance A has
//            unlimited bursts, instance B has BURST_MAX=4. Each requester is
//            fed from a beat queue; the expected output order is pushed to a
//            scoreboard as stimulus is set up and popped as beats leave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_rr_arbiter;

   localparam int NI = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NI-1:0]    a_i_rdy, a_i_en, a_i_last, b_i_rdy, b_i_en, b_i_last;
   logic [NI*DW-1:0] a_i_data, b_i_data;
   logic             a_o_rdy, a_o_en, a_o_last, b_o_rdy, b_o_en, b_o_last;
   logic [DW-1:0]    a_o_data, b_o_data;
   logic [2:0]       a_o_id, b_o_id;

   stream_rr_arbiter #(.NI(NI), .DW(DW), .BURST_MAX(0)) dut_a (
      .clk(clk), .rst(rst), .i_rdy(a_i_rdy), .i_en(a_i_en), .i_data(a_i_data),
      .i_last(a_i_last), .o_rdy(a_o_rdy), .o_en(a_o_en), .o_data(a_o_data),
      .o_last(a_o_last), .o_id(a_o_id)
   );

   stream_rr_arbiter #(.NI(NI), .DW(DW), .BURST_MAX(4)) dut_b (
      .clk(clk), .rst(rst), .i_rdy(b_i_rdy), .i_en(b_i_en), .i_data(b_i_data),
      .i_last(b_i_last), .o_rdy(b_o_rdy), .o_en(b_o_en), .o_data(b_o_data),
      .o_last(b_o_last), .o_id(b_o_id)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [8:0]  src_a [NI][$];   // {last, data}
   logic [8:0]  src_b [NI][$];
   logic [11:0] sb_a [$];        // {data, last, id}
   logic [11:0] sb_b [$];
   int          out_cyc [$];     // cycles of beats leaving instance A
   int          acc_a [NI];
   logic [NI-1:0] hold_a;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      logic [8:0] f;
      for (int k = 0; k < NI; k++) begin
         f = (src_a[k].size() != 0) ? src_a[k][0] : 9'd0;
         a_i_en[k]           = (src_a[k].size() != 0) && !hold_a[k];
         a_i_last[k]         = f[8];
         a_i_data[k*DW +: DW] = f[7:0];
         f = (src_b[k].size() != 0) ? src_b[k][0] : 9'd0;
         b_i_en[k]           = (src_b[k].size() != 0);
         b_i_last[k]         = f[8];
         b_i_data[k*DW +: DW] = f[7:0];
      end
   endtask

   // One clock: sample handshakes and check outputs at the falling edge,
   // then retire accepted source beats and redrive just after the rising edge.
   task automatic cycle();
      logic [NI-1:0] acc_va, acc_vb;
      logic [11:0]   e;
      @(negedge clk);
      acc_va = a_i_en & a_i_rdy;
      acc_vb = b_i_en & b_i_rdy;
      if (a_o_en && a_o_rdy) begin
         out_cyc.push_back(cyc);
         if (sb_a.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL a_extra_beat observed=%0h expected=none", {a_o_data, a_o_last, a_o_id});
         end else begin
            e = sb_a.pop_front();
            chk("a_out_beat", 32'({a_o_data, a_o_last, a_o_id}), 32'(e));
         end
      end
      if (b_o_en && b_o_rdy) begin
         if (sb_b.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL b_extra_beat observed=%0h expected=none", {b_o_data, b_o_last, b_o_id});
         end else begin
            e = sb_b.pop_front();
            chk("b_out_beat", 32'({b_o_data, b_o_last, b_o_id}), 32'(e));
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      for (int k = 0; k < NI; k++) begin
         if (acc_va[k]) begin
            void'(src_a[k].pop_front());
            acc_a[k]++;
         end
         if (acc_vb[k]) begin
            void'(src_b[k].pop_front());
         end
      end
      drive();
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((sb_a.size() != 0 || sb_b.size() != 0) && n < max) begin
         cycle();
         n++;
      end
      chk("drain_left", 32'(sb_a.size() + sb_b.size()), 32'd0);
      repeat (2) cycle();
   endtask

   initial begin
      int c0, n;
      a_o_rdy = 1'b1;
      b_o_rdy = 1'b1;
      hold_a  = '0;
      for (int k = 0; k < NI; k++) acc_a[k] = 0;
      drive();
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      chk("rst_o_en", 32'(a_o_en), 32'd0);
      chk("rst_o_data", 32'(a_o_data), 32'd0);
      chk("rst_o_last", 32'(a_o_last), 32'd0);
      chk("rst_o_id", 32'(a_o_id), 32'd0);
      chk("rst_i_rdy", 32'(a_i_rdy), 32'd0);
      chk("rst_b_o_en", 32'(b_o_en), 32'd0);
      chk("rst_b_i_rdy", 32'(b_i_rdy), 32'd0);
      rst = 1'b0;
      cycle();

      // Round robin: every requester offers two 1-beat packets
      for (int k = 0; k < NI; k++) begin
         src_a[k].push_back({1'b1, 8'(8'h40 + k)});
         src_a[k].push_back({1'b1, 8'(8'h50 + k)});
      end
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < NI; k++)
            sb_a.push_back({8'(8'h40 + 16*r + k), 1'b1, 3'(k)});
      out_cyc.delete();
      drive();
      drain(100);
      chk("rr_count", 32'(out_cyc.size()), 32'd8);
      for (int i = 1; i < out_cyc.size(); i++)
         chk("rr_gap", 32'(out_cyc[i] - out_cyc[i-1]), 32'd2);

      // Single source with latency check
      src_a[2].push_back({1'b0, 8'h11});
      src_a[2].push_back({1'b0, 8'h12});
      src_a[2].push_back({1'b0, 8'h13});
      src_a[2].push_back({1'b1, 8'h14});
      sb_a.push_back({8'h11, 1'b0, 3'd2});
      sb_a.push_back({8'h12, 1'b0, 3'd2});
      sb_a.push_back({8'h13, 1'b0, 3'd2});
      sb_a.push_back({8'h14, 1'b1, 3'd2});
      out_cyc.delete();
      drive();
      c0 = cyc;
      drain(50);
      chk("single_count", 32'(out_cyc.size()), 32'd4);
      if (out_cyc.size() == 4) begin
         chk("single_latency", 32'(out_cyc[0] - c0), 32'd2);
         chk("single_consecutive", 32'(out_cyc[3] - out_cyc[0]), 32'd3);
      end

      // Backpressure: o_rdy low while the packet arrives
      a_o_rdy = 1'b0;
      acc_a[1] = 0;
      src_a[1].push_back({1'b0, 8'h21});
      src_a[1].push_back({1'b0, 8'h22});
      src_a[1].push_back({1'b1, 8'h23});
      sb_a.push_back({8'h21, 1'b0, 3'd1});
      sb_a.push_back({8'h22, 1'b0, 3'd1});
      sb_a.push_back({8'h23, 1'b1, 3'd1});
      drive();
      n = 0;
      while (!a_o_en && n < 20) begin
         cycle();
         n++;
      end
      chk("bp_first_oen", 32'(a_o_en), 32'd1);
      repeat (5) begin
         cycle();
         chk("bp_hold_data", 32'({a_o_en, a_o_data}), 32'h121);
      end
      chk("bp_accepted", 32'(acc_a[1]), 32'd2);
      chk("bp_i_rdy_low", 32'(a_i_rdy), 32'd0);
      a_o_rdy = 1'b1;
      drain(50);

      // Packet lock: requester 0 stalls mid-packet, requester 1 waits
      acc_a[0] = 0;
      for (int i = 0; i < 6; i++) begin
         src_a[0].push_back({(i == 5), 8'(8'h61 + i)});
         sb_a.push_back({8'(8'h61 + i), (i == 5), 3'd0});
      end
      src_a[1].push_back({1'b1, 8'h71});
      sb_a.push_back({8'h71, 1'b1, 3'd1});
      drive();
      n = 0;
      while (acc_a[0] < 3 && n < 30) begin
         cycle();
         n++;
      end
      chk("lock_accepted", 32'(acc_a[0]), 32'd3);
      hold_a[0] = 1'b1;
      drive();
      repeat (3) begin
         cycle();
         chk("lock_i_rdy", 32'(a_i_rdy), 32'b0001);
      end
      hold_a[0] = 1'b0;
      drive();
      drain(60);

      // Reset mid-packet: move ptr to 3 first, then abort a 5-beat packet
      src_a[2].push_back({1'b1, 8'h81});
      sb_a.push_back({8'h81, 1'b1, 3'd2});
      drive();
      drain(50);
      a_o_rdy = 1'b0;
      acc_a[2] = 0;
      for (int i = 0; i < 5; i++) src_a[2].push_back({(i == 4), 8'(8'h91 + i)});
      drive();
      n = 0;
      while ((acc_a[2] < 2 || a_i_rdy[2]) && n < 30) begin
         cycle();
         n++;
      end
      chk("rst_pre_accepted", 32'(acc_a[2]), 32'd2);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      src_a[2].delete();
      drive();
      chk("rst_mid_o_en", 32'(a_o_en), 32'd0);
      chk("rst_mid_i_rdy", 32'(a_i_rdy), 32'd0);
      a_o_rdy = 1'b1;
      src_a[0].push_back({1'b1, 8'hA1});
      src_a[3].push_back({1'b1, 8'hA3});
      sb_a.push_back({8'hA1, 1'b1, 3'd0});
      sb_a.push_back({8'hA3, 1'b1, 3'd3});
      drive();
      drain(50);

      // Burst limit on instance B: ptr to 3, then 10 beats from 3 vs one from 0
      src_b[2].push_back({1'b1, 8'h20});
      sb_b.push_back({8'h20, 1'b1, 3'd2});
      drive();
      drain(50);
      for (int i = 0; i < 10; i++) src_b[3].push_back({1'b0, 8'(8'h30 + i)});
      src_b[0].push_back({1'b1, 8'hB0});
      for (int i = 0; i < 4; i++) sb_b.push_back({8'(8'h30 + i), 1'b0, 3'd3});
      sb_b.push_back({8'hB0, 1'b1, 3'd0});
      for (int i = 4; i < 10; i++) sb_b.push_back({8'(8'h30 + i), 1'b0, 3'd3});
      drive();
      drain(100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
